// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk50 timebase generators.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Holds the system clock rate, the common divisor constants used by the
// display, debounce and timekeeping consumers, and width helpers.
package clk_div_pkg;

    localparam int CLK50_HZ  = 50_000_000;

    // Divisors give the tick period in clk50 cycles; sq runs at half the tick rate.
    localparam int DIV_1HZ   = 25_000_000;
    localparam int DIV_100HZ = 250_000;
    localparam int DIV_1KHZ  = 25_000;

    // Bits needed to hold a divisor up to max_div.
    function automatic int div_width(input int max_div);
        return (max_div < 2) ? 1 : $clog2(max_div + 1);
    endfunction

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable tick channel: counter, active/shadow divisor, tick and sq.
// Latency: tick registered one edge after the q==div-1 cycle; divisor applied at the next wrap.
// Backpressure: none; en_i stalls the count, writes are always accepted.
//
// Ports:
//   clk50, reset    clock, asynchronous active-high reset
//   en_i            count enable
//   sync_i          restart counter, clear tick/sq, apply any new divisor now
//   wr_i, wr_div_i  accepted divisor write (already validated by the top)
//   tick_o, sq_o    one-cycle period enable, square output
// Square output logic exists only when CLKDIV_SQUARE_EN is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W       = 26,
    parameter int DEF_DIV = DIV_1HZ
) (
    input  logic         clk50,
    input  logic         reset,
    input  logic         en_i,
    input  logic         sync_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_div_i,
    output logic         tick_o,
    output logic         sq_o
);

    localparam logic [W-1:0] DEF = W'(DEF_DIV);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] q_q, q_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] sdiv_q, sdiv_d;
    logic         pend_q, pend_d;
    logic         tick_q, tick_d;

    logic         wrap;
    logic         apply;
    logic         have_new;
    logic [W-1:0] new_div;

    // ">=" rather than "==" so that a divisor shrunk below a held count
    // wraps on the next enabled cycle instead of running through 2^W.
    assign wrap     = en_i && (q_q >= (div_q - ONE));

    // Divisor changes only at a period boundary, on sync, or while the
    // channel is idle, so a running period is never truncated.
    assign apply    = sync_i || wrap || !en_i;
    assign have_new = wr_i || pend_q;
    assign new_div  = wr_i ? wr_div_i : sdiv_q;

    always_comb begin
        q_d    = q_q;
        div_d  = div_q;
        sdiv_d = wr_i ? wr_div_i : sdiv_q;
        pend_d = pend_q || wr_i;
        tick_d = wrap && !sync_i;

        if (sync_i || wrap) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = q_q + ONE;
        end

        if (apply && have_new) begin
            div_d  = new_div;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            div_q  <= DEF;
            sdiv_q <= DEF;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            div_q  <= div_d;
            sdiv_q <= sdiv_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef CLKDIV_SQUARE_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (sync_i) begin
            sq_d = 1'b0;
        end else if (wrap) begin
            sq_d = ~sq_q;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator on clk50.
// Latency: tick one edge after wrap; err one edge after the rejected load.
// Backpressure: none; every load is accepted or flagged on err.
//
// Ports:
//   clk50, reset               clock, asynchronous active-high reset
//   en[CH]                     per-channel count enable
//   sync                       restart all channels in phase
//   load, load_sel, load_div   single-cycle divisor write
//   tick[CH], sq[CH]           period enables and square outputs
//   err                        one-cycle pulse on rejected write
// Define CLKDIV_SQUARE_EN to build the sq flops; otherwise sq is tied low.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CH      = 4,
    parameter int W       = 26,
    parameter int DEF_DIV = DIV_1HZ,
    localparam int SELW   = sel_width(CH)
) (
    input  logic            clk50,
    input  logic            reset,
    input  logic [CH-1:0]   en,
    input  logic            sync,
    input  logic            load,
    input  logic [SELW-1:0] load_sel,
    input  logic [W-1:0]    load_div,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   sq,
    output logic            err
);

    // One extra bit so CH itself is representable when CH is a power of two.
    localparam logic [SELW:0] CH_L = (SELW + 1)'(CH);

    logic [SELW:0] sel_ext;
    logic          sel_oob;
    logic          bad_wr;
    logic          good_wr;
    logic          err_q, err_d;

    assign sel_ext = {1'b0, load_sel};
    assign sel_oob = (sel_ext >= CH_L);
    assign bad_wr  = load && ((load_div == '0) || sel_oob);
    assign good_wr = load && !bad_wr;
    assign err_d   = bad_wr;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic wr_this;

        assign wr_this = good_wr && (sel_ext == (SELW + 1)'(i));

        clk_div_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk50    (clk50),
            .reset    (reset),
            .en_i     (en[i]),
            .sync_i   (sync),
            .wr_i     (wr_this),
            .wr_div_i (load_div),
            .tick_o   (tick[i]),
            .sq_o     (sq[i])
        );
    end

endmodule
